// File: rtl/mem_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: state encoding,
// access-length bounds and default SRAM geometry.
package mem_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } sram_state_e;

    localparam int WAIT_CYCLES_MIN = 2;
    localparam int WAIT_CYCLES_MAX = 15;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int SRAM_ADDR_W_DEF = 18;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_sram_ctrl.sv
// MEM-stage responder: latches one load/store command, runs a fixed-length
// asynchronous SRAM access while stalling the pipeline, returns load data.
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   is_mem_cmd,
    input  logic                   mem_store,
    input  logic [15:0]            addr,
    input  logic [15:0]            wdata,
    output logic                   sram_busy,
    output logic [15:0]            rdata,
    output logic                   rdata_valid,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    sram_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [15:0]            addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   store_q, store_d;
    logic [15:0]            rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]            dq_out_q, dq_out_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_n_q, we_n_d;
    logic                   bs_n_q, bs_n_d;

    assign sram_busy = (state_q == ST_ACCESS) || (state_q == ST_IDLE && is_mem_cmd);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        store_d     = store_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        bs_n_d      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (is_mem_cmd) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                    addr_d  = addr;
                    wdata_d = wdata;
                    store_d = mem_store;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    if (!store_q) begin
                        rdata_d  = sram_dq_in;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Strobes are registered, so they are decoded from the upcoming state/count.
        if (state_d == ST_ACCESS) begin
            ce_n_d      = 1'b0;
            bs_n_d      = 1'b0;
            sram_addr_d = SRAM_ADDR_W'(addr_d);
            if (store_d) begin
                dq_oe_d  = 1'b1;
                dq_out_d = wdata_d;
                we_n_d   = (cnt_d == LAST);
            end else begin
                oe_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            store_q     <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            bs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            store_q     <= store_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            bs_n_q      <= bs_n_d;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = bs_n_q;
    assign sram_lb_n   = bs_n_q;

endmodule
